// File: rtl/dvs_mode_ctrl.sv
// Activity-driven low-power mode controller: measures bit-toggle activity of a sample stream
// per window and steers a downstream FIR into/out of low-power mode with hysteresis.
module dvs_mode_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned LO_TH  = 32,
  parameter int unsigned HI_TH  = 64,
  parameter int unsigned SETTLE = 4,
  localparam int unsigned ACT_W = $clog2(WINDOW * DATA_W) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic                     force_normal,
  output logic                     low_power_mode,
  output logic                     mode_busy,
  output logic                     win_done,
  output logic [ACT_W-1:0]         activity
);

  localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [ACT_W-1:0]  LoTh       = ACT_W'(LO_TH);
  localparam logic [ACT_W-1:0]  HiTh       = ACT_W'(HI_TH);
  localparam logic [CNT_W-1:0]  CntLast    = CNT_W'(WINDOW - 1);
  localparam logic [SCNT_W-1:0] SettleLoad = SCNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {StNormal, StSettleLo, StLow, StSettleHi} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] prev_q;
  logic [ACT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SCNT_W-1:0] scnt_q;

  logic [DATA_W-1:0] diff;
  logic [ACT_W-1:0]  toggles;
  logic [ACT_W-1:0]  sum;
  logic              closing;
  logic              sum_lo;
  logic              sum_hi;

  always_comb begin
    diff    = $unsigned(data_in) ^ prev_q;
    toggles = '0;
    for (int i = 0; i < DATA_W; i++) begin
      toggles = toggles + ACT_W'(diff[i]);
    end
    sum     = acc_q + toggles;
    closing = data_valid && (cnt_q == CntLast);
    sum_lo  = closing && (sum < LoTh);
    sum_hi  = closing && (sum > HiTh);
  end

  // Window accumulation runs independently of the mode FSM, including during settle states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      win_done <= 1'b0;
      activity <= '0;
    end else begin
      win_done <= closing;
      if (data_valid) begin
        prev_q <= $unsigned(data_in);
        cnt_q  <= cnt_q + CNT_W'(1);
        if (closing) begin
          activity <= sum;
          acc_q    <= '0;
        end else begin
          acc_q    <= sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StNormal;
      scnt_q         <= '0;
      low_power_mode <= 1'b0;
      mode_busy      <= 1'b0;
    end else begin
      case (state_q)
        StNormal: begin
          if (sum_lo && !force_normal) begin
            state_q        <= StSettleLo;
            scnt_q         <= SettleLoad;
            low_power_mode <= 1'b1;
            mode_busy      <= 1'b1;
          end
        end
        StSettleLo: begin
          // An override aborts entry immediately and restarts the settle period.
          if (force_normal) begin
            state_q        <= StSettleHi;
            scnt_q         <= SettleLoad;
            low_power_mode <= 1'b0;
          end else if (scnt_q == '0) begin
            state_q   <= StLow;
            mode_busy <= 1'b0;
          end else begin
            scnt_q <= scnt_q - SCNT_W'(1);
          end
        end
        StLow: begin
          if (force_normal || sum_hi) begin
            state_q        <= StSettleHi;
            scnt_q         <= SettleLoad;
            low_power_mode <= 1'b0;
            mode_busy      <= 1'b1;
          end
        end
        StSettleHi: begin
          if (scnt_q == '0) begin
            state_q   <= StNormal;
            mode_busy <= 1'b0;
          end else begin
            scnt_q <= scnt_q - SCNT_W'(1);
          end
        end
        default: begin
          state_q        <= StNormal;
          scnt_q         <= '0;
          low_power_mode <= 1'b0;
          mode_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_mode_ctrl.sv
// Self-checking bench for dvs_mode_ctrl: directed scenarios plus randomized traffic, all
// checked each cycle against a behavioural model of window sums and mode timing.
module tb_dvs_mode_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WINDOW = 16;
  localparam int unsigned LO_TH  = 32;
  localparam int unsigned HI_TH  = 64;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned ACT_W  = $clog2(WINDOW * DATA_W) + 1;

  localparam int MN = 0, MSL = 1, ML = 2, MSH = 3;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              force_normal;
  logic              low_power_mode;
  logic              mode_busy;
  logic              win_done;
  logic [ACT_W-1:0]  activity;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_prev;
  int                m_acc, m_cnt, m_act, m_wd, m_mode, m_left;
  logic [DATA_W-1:0] tb_prev;

  dvs_mode_ctrl #(
    .DATA_W(DATA_W),
    .WINDOW(WINDOW),
    .LO_TH (LO_TH),
    .HI_TH (HI_TH),
    .SETTLE(SETTLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .force_normal  (force_normal),
    .low_power_mode(low_power_mode),
    .mode_busy     (mode_busy),
    .win_done      (win_done),
    .activity      (activity)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_prev = '0; m_acc = 0; m_cnt = 0; m_act = 0; m_wd = 0; m_mode = MN; m_left = 0;
  endfunction

  // Window sums from plain counting; mode timing as "busy cycles remaining".
  function automatic void model_edge(input logic [DATA_W-1:0] d, input logic v, input logic f);
    int sum;
    bit closing;
    closing = 0;
    sum = 0;
    if (v) begin
      sum = m_acc + $countones(d ^ m_prev);
      m_prev = d;
      m_cnt++;
      if (m_cnt == WINDOW) begin
        closing = 1;
        m_cnt = 0;
        m_act = sum;
        m_acc = 0;
      end else begin
        m_acc = sum;
      end
    end
    m_wd = closing ? 1 : 0;
    case (m_mode)
      MN: if (closing && sum < LO_TH && !f) begin m_mode = MSL; m_left = SETTLE; end
      MSL: begin
        if (f) begin
          m_mode = MSH; m_left = SETTLE;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = ML;
        end
      end
      ML: if (f || (closing && sum > HI_TH)) begin m_mode = MSH; m_left = SETTLE; end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = MN;
      end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".lp"}, 32'(low_power_mode), 32'((m_mode == MSL) || (m_mode == ML)));
    chk({tag, ".busy"}, 32'(mode_busy), 32'((m_mode == MSL) || (m_mode == MSH)));
    chk({tag, ".wd"}, 32'(win_done), 32'(m_wd));
    chk({tag, ".act"}, 32'(activity), 32'(m_act));
  endtask

  task automatic step(input logic [DATA_W-1:0] d, input logic v, input logic f);
    data_in = d;
    data_valid = v;
    force_normal = f;
    @(posedge clk);
    model_edge(d, v, f);
    if (v) tb_prev = d;
    #1;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_reset();
    tb_prev = '0;
    check_outputs("rst_async");
    for (int i = 0; i < cycles; i++) begin
      data_in = 16'($urandom);
      data_valid = 1'b1;
      force_normal = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    data_valid = 1'b0;
    force_normal = 1'b0;
    reset = 1'b1;
  endtask

  // One window whose toggle sum is exactly target, optionally with invalid gaps.
  task automatic send_window(input int target, input bit gaps, input logic f);
    int rem;
    int k;
    logic [DATA_W-1:0] mask;
    rem = target;
    for (int i = 0; i < WINDOW; i++) begin
      k = (rem > DATA_W) ? DATA_W : rem;
      mask = (k == DATA_W) ? '1 : 16'((32'd1 << k) - 1);
      rem -= k;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) step(16'($urandom), 1'b0, f);
      end
      step(tb_prev ^ mask, 1'b1, f);
    end
  endtask

  int busy_cycles;
  int tgt;

  initial begin
    reset = 1'b0;
    data_in = '0;
    data_valid = 1'b0;
    force_normal = 1'b0;
    tb_prev = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset hold, then first win_done after exactly 16 valid samples
    apply_reset(4);
    for (int i = 0; i < WINDOW; i++) begin
      step(16'($urandom), 1'b1, 1'b0);
      chk("first_wd", 32'(win_done), 32'(i == WINDOW - 1));
    end
    idle(6);

    // Quiet entry
    apply_reset(2);
    for (int i = 0; i < WINDOW; i++) step(16'h1234, 1'b1, 1'b0);
    chk("quiet_act", 32'(activity), 32'd5);
    chk("quiet_lp", 32'(low_power_mode), 32'd1);
    busy_cycles = mode_busy ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step(16'h1234, 1'b0, 1'b0);
      busy_cycles += mode_busy ? 1 : 0;
    end
    chk("quiet_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("quiet_low_lp", 32'(low_power_mode), 32'd1);

    // Busy exit
    for (int i = 0; i < WINDOW; i++) step((i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    chk("exit_act_ge240", 32'(activity >= 240), 32'd1);
    chk("exit_lp", 32'(low_power_mode), 32'd0);
    busy_cycles = mode_busy ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      busy_cycles += mode_busy ? 1 : 0;
    end
    chk("exit_busy_cycles", 32'(busy_cycles), 32'd4);

    // Hysteresis band edges
    send_window(LO_TH, 1'b0, 1'b0);
    chk("th_lo_eq_act", 32'(activity), 32'(LO_TH));
    idle(2);
    chk("th_lo_eq_lp", 32'(low_power_mode), 32'd0);
    send_window(LO_TH - 1, 1'b0, 1'b0);
    chk("th_lo_below_lp", 32'(low_power_mode), 32'd1);
    idle(6);
    send_window(HI_TH, 1'b0, 1'b0);
    chk("th_hi_eq_act", 32'(activity), 32'(HI_TH));
    idle(2);
    chk("th_hi_eq_lp", 32'(low_power_mode), 32'd1);
    send_window(HI_TH + 1, 1'b0, 1'b0);
    chk("th_hi_above_lp", 32'(low_power_mode), 32'd0);
    idle(6);

    // Valid gaps leave window sums unchanged
    tgt = $urandom_range(33, 200);
    apply_reset(1);
    send_window(tgt, 1'b0, 1'b0);
    chk("nogap_act", 32'(activity), 32'(tgt));
    apply_reset(1);
    send_window(tgt, 1'b1, 1'b0);
    chk("gap_act", 32'(activity), 32'(tgt));
    idle(2);

    // Override abort in second cycle of settle-low
    send_window(0, 1'b0, 1'b0);
    chk("ovr_enter_lp", 32'(low_power_mode), 32'd1);
    step(tb_prev, 1'b0, 1'b0);
    step(tb_prev, 1'b0, 1'b1);
    chk("ovr_abort_lp", 32'(low_power_mode), 32'd0);
    chk("ovr_abort_busy", 32'(mode_busy), 32'd1);
    idle(6);
    chk("ovr_normal_busy", 32'(mode_busy), 32'd0);
    for (int w = 0; w < 2; w++) begin
      send_window(0, 1'b0, 1'b1);
      chk("ovr_hold_lp", 32'(low_power_mode), 32'd0);
    end
    idle(2);

    // Mid-window reset
    for (int i = 0; i < 10; i++) step(16'($urandom), 1'b1, 1'b0);
    apply_reset(2);
    for (int i = 0; i < WINDOW; i++) begin
      step(tb_prev, 1'b1, 1'b0);
      chk("midwin_wd", 32'(win_done), 32'(i == WINDOW - 1));
      if (i < WINDOW - 1) chk("midwin_lp", 32'(low_power_mode), 32'd0);
    end
    idle(6);

    // Reset during settle-high
    step(tb_prev, 1'b0, 1'b1);
    chk("midsh_busy", 32'(mode_busy), 32'(1));
    apply_reset(1);
    for (int i = 0; i < WINDOW; i++) begin
      step(16'($urandom), 1'b1, 1'b0);
      chk("midsh_wd", 32'(win_done), 32'(i == WINDOW - 1));
      if (i < WINDOW - 1) chk("midsh_lp", 32'(low_power_mode), 32'd0);
    end
    idle(6);

    // Randomized traffic with varying activity levels
    for (int w = 0; w < 150; w++) begin
      int lvl;
      logic [DATA_W-1:0] d;
      lvl = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0) apply_reset($urandom_range(1, 3));
      for (int i = 0; i < 20; i++) begin
        case (lvl)
          0: d = tb_prev;
          1: d = tb_prev ^ (16'd1 << $urandom_range(0, 15));
          2: d = tb_prev ^ (16'($urandom) & 16'h00FF);
          default: d = 16'($urandom);
        endcase
        step(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_mode_ctrl.md
DVS_MODE_CTRL -- requirements
Module: dvs_mode_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide the following parameters:
- DATA_W, default 16: sample width.
- WINDOW, default 16: valid samples per activity window (power of 2).
- LO_TH, default 32: window toggle count below which the block enters low-power mode.
- HI_TH, default 64: window toggle count above which the block exits low-power mode.
- SETTLE, default 4: cycles the block holds in each transition state.
REQ-003 The block SHALL provide the following ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low; 0 = reset.
- data_in, input, DATA_W (signed): sample stream also fed to dvs_FIR.data_in.
- data_valid, input, 1: data_in is a valid sample this cycle.
- force_normal, input, 1: level request to leave or block low-power mode.
- low_power_mode, output, 1: drives dvs_FIR.low_power_mode.
- mode_busy, output, 1: high while the FSM is in a settle state.
- win_done, output, 1: one-cycle pulse after each window closes.
- activity, output, clog2(WINDOW*DATA_W)+1 (9 at defaults): toggle sum of the last closed window.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 On each clk edge with data_valid=1, the block SHALL compute toggles = popcount(data_in XOR prev), then update prev <= data_in and acc <= acc + toggles.
REQ-006 Cycles with data_valid=0 SHALL leave prev, acc and the sample counter unchanged.
REQ-007 A sample counter of width clog2(WINDOW) SHALL count valid samples and wrap naturally. The valid sample that takes it from WINDOW-1 to 0 is the closing sample.
REQ-008 On the closing-sample edge, the block SHALL:
- load activity with sum = acc + toggles of that sample;
- clear acc to 0;
- set win_done to 1 for exactly one cycle.
REQ-009 acc and activity SHALL NOT saturate. The maximum sum, WINDOW*DATA_W (256 at defaults), SHALL fit their width.
REQ-010 The FSM SHALL have four states, with low_power_mode and mode_busy as listed:
- NORMAL: low_power_mode=0, mode_busy=0.
- SETTLE_LO: low_power_mode=1, mode_busy=1.
- LOW: low_power_mode=1, mode_busy=0.
- SETTLE_HI: low_power_mode=0, mode_busy=1.
REQ-011 In NORMAL, on a closing-sample edge with sum < LO_TH (strict) and force_normal=0, the FSM SHALL go to SETTLE_LO. low_power_mode is then 1 in the following cycle (latency 1 from the closing sample).
REQ-012 In LOW, the FSM SHALL go to SETTLE_HI on either event below; low_power_mode is then 0 in the following cycle:
- a closing-sample edge with sum > HI_TH (strict);
- any edge with force_normal=1.
REQ-013 Sums equal to LO_TH or HI_TH SHALL cause no transition (hysteresis band inclusive).
REQ-014 Each settle state SHALL run a down-counter loaded with SETTLE-1 on entry and SHALL exit when the counter reaches 0, giving exactly SETTLE cycles of mode_busy=1:
- SETTLE_LO exits to LOW.
- SETTLE_HI exits to NORMAL.
REQ-015 In settle states, window accumulation SHALL continue, but threshold results SHALL be ignored.
REQ-016 force_normal=1 in SETTLE_LO SHALL abort to SETTLE_HI on the next edge, with the counter reloaded.
REQ-017 force_normal has no effect in NORMAL or SETTLE_HI other than blocking entry to SETTLE_LO.
REQ-018 The first valid sample after reset SHALL be compared against prev=0.

Reset
REQ-019 While reset=0, the block SHALL asynchronously clear the following and hold them cleared:
- state to NORMAL;
- prev, acc, the sample counter and the settle counter to 0;
- low_power_mode, mode_busy, win_done and activity to 0.
REQ-020 A reset asserted mid-window or mid-settle SHALL discard all partial progress. The first valid sample after release starts a new window.

Verification
REQ-021 Reset: hold reset=0 with random data_in and data_valid=1 -> all outputs 0. After release, win_done first pulses after the 16th valid sample.
REQ-022 Quiet entry: 16 valid samples of 16'h1234 -> activity=5, low_power_mode=1 the cycle after the 16th sample, mode_busy=1 for exactly 4 cycles, then state LOW.
REQ-023 Busy exit: from LOW, 16 samples alternating 16'h0000/16'hFFFF -> activity>=240, low_power_mode=0 the next cycle, mode_busy=1 for 4 cycles, then NORMAL.
REQ-024 Thresholds and valid gaps: crafted windows with sum=32 in NORMAL and sum=64 in LOW -> no mode change. Inserting data_valid=0 gaps -> identical activity values to the gap-free run.
REQ-025 Override: assert force_normal in the 2nd cycle of SETTLE_LO -> low_power_mode=0 next edge, 4 busy cycles, NORMAL. Holding force_normal through quiet windows -> low_power_mode stays 0.
REQ-026 Mid-operation reset: assert reset=0 after 10 samples of a window, or in SETTLE_HI, then release -> all state cleared, next window closes after 16 fresh samples, low_power_mode=0 until then.
